// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer and its collision helpers.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        DYING = 3'd2,
        OVER  = 3'd3,
        WIN   = 3'd4
    } game_state_t;

    localparam int SPRITE_SIZE_DEFAULT = 16;

    localparam logic [1:0] GHOST_BLINKY = 2'd0;
    localparam logic [1:0] GHOST_PINKY  = 2'd1;
    localparam logic [1:0] GHOST_INKY   = 2'd2;
    localparam logic [1:0] GHOST_CLYDE  = 2'd3;

    // x^5 + x^3 + 1 Fibonacci step; period 31 from any nonzero seed.
    function automatic logic [4:0] lfsr_next(input logic [4:0] cur);
        return {cur[3:0], cur[4] ^ cur[2]};
    endfunction

endpackage

// File: rtl/game_state_ctrl_sprite_overlap.sv
// Bounding-box overlap test between two equal-size square sprites.
// Purely combinational; hit when both axis distances are below SIZE.
module sprite_overlap
    import game_pkg::*;
#(
    parameter int SIZE = SPRITE_SIZE_DEFAULT
) (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    output logic       hit
);

    localparam logic [10:0] SIZE_W = 11'(SIZE);

    logic [10:0] dx;
    logic [10:0] dy;

    assign dx  = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
    assign dy  = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
    assign hit = (dx < SIZE_W) && (dy < SIZE_W);

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: start/death/win FSM, lives, death freeze timer and ghost LFSR.
// All outputs are registered and change on the same edge as the state.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int         SPRITE_SIZE  = SPRITE_SIZE_DEFAULT,
    parameter int         LIVES_INIT   = 3,
    parameter int         DEATH_FRAMES = 60,
    parameter logic [4:0] LFSR_SEED    = 5'b00001
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       key_start,
    input  logic       all_eaten,
    input  logic [9:0] PacX,
    input  logic [9:0] PacY,
    input  logic [9:0] GhostX0,
    input  logic [9:0] GhostX1,
    input  logic [9:0] GhostX2,
    input  logic [9:0] GhostX3,
    input  logic [9:0] GhostY0,
    input  logic [9:0] GhostY1,
    input  logic [9:0] GhostY2,
    input  logic [9:0] GhostY3,
    output logic       start_game,
    output logic       game_over,
    output logic       win,
    output logic [1:0] lives,
    output logic [1:0] hit_ghost,
    output logic       respawn,
    output logic [4:0] counter
);

    localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [7:0] TIMER_LAST = 8'(DEATH_FRAMES - 1);

    game_state_t state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [1:0]  hit_ghost_q, hit_ghost_d;
    logic [7:0]  timer_q, timer_d;
    logic [4:0]  counter_q, counter_d;
    logic        key_start_q;
    logic        start_game_q, start_game_d;
    logic        game_over_q, game_over_d;
    logic        win_q, win_d;
    logic        respawn_q, respawn_d;

    logic [9:0] ghost_x [4];
    logic [9:0] ghost_y [4];
    logic [3:0] hit;
    logic       any_hit;
    logic [1:0] hit_idx;
    logic       start_edge;

    assign ghost_x[0] = GhostX0;
    assign ghost_x[1] = GhostX1;
    assign ghost_x[2] = GhostX2;
    assign ghost_x[3] = GhostX3;
    assign ghost_y[0] = GhostY0;
    assign ghost_y[1] = GhostY1;
    assign ghost_y[2] = GhostY2;
    assign ghost_y[3] = GhostY3;

    for (genvar g = 0; g < 4; g++) begin : g_overlap
        sprite_overlap #(.SIZE(SPRITE_SIZE)) u_overlap (
            .ax  (PacX),
            .ay  (PacY),
            .bx  (ghost_x[g]),
            .by  (ghost_y[g]),
            .hit (hit[g])
        );
    end

    assign any_hit    = |hit;
    assign start_edge = key_start & ~key_start_q;

    always_comb begin
        hit_idx = GHOST_CLYDE;
        if (hit[0])      hit_idx = GHOST_BLINKY;
        else if (hit[1]) hit_idx = GHOST_PINKY;
        else if (hit[2]) hit_idx = GHOST_INKY;
    end

    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        hit_ghost_d = hit_ghost_q;
        timer_d     = timer_q;
        counter_d   = lfsr_next(counter_q);
        case (state_q)
            IDLE, OVER, WIN: begin
                if (start_edge) begin
                    state_d = PLAY;
                    lives_d = LIVES_RST;
                end
            end
            PLAY: begin
                // Positions are stale on the respawn cycle, so collisions wait a frame.
                if (all_eaten) begin
                    state_d = WIN;
                end else if (any_hit && !respawn_q) begin
                    state_d     = DYING;
                    lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    hit_ghost_d = hit_idx;
                    timer_d     = 8'd0;
                end
            end
            DYING: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = (lives_q == 2'd0) ? OVER : PLAY;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        start_game_d = (state_d == PLAY);
        game_over_d  = (state_d == OVER) || (state_d == WIN);
        win_d        = (state_d == WIN);
        respawn_d    = (state_d == PLAY) && (state_q != PLAY);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            lives_q      <= LIVES_RST;
            hit_ghost_q  <= 2'd0;
            timer_q      <= 8'd0;
            counter_q    <= LFSR_SEED;
            key_start_q  <= 1'b0;
            start_game_q <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
            respawn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            hit_ghost_q  <= hit_ghost_d;
            timer_q      <= timer_d;
            counter_q    <= counter_d;
            key_start_q  <= key_start;
            start_game_q <= start_game_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
            respawn_q    <= respawn_d;
        end
    end

    assign start_game = start_game_q;
    assign game_over  = game_over_q;
    assign win        = win_q;
    assign lives      = lives_q;
    assign hit_ghost  = hit_ghost_q;
    assign respawn    = respawn_q;
    assign counter    = counter_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game sequencer. It consumes the Pac-Man position and all four ghost positions.
- It detects Pac-Man/ghost collisions, tracks lives, and detects the win condition.
- It drives the start_game / game_over controls that freeze the ghost and player motion blocks.
- It also supplies the 5-bit pseudo-random counter that the ghost movement blocks use for turn decisions.

Parameters:
- SPRITE_SIZE, 16, sprite bounding-box edge in pixels. Overlap threshold.
- LIVES_INIT, 3, lives loaded at game start. Range 1..3.
- DEATH_FRAMES, 60, frames spent in death freeze. Range 1..255.
- LFSR_SEED, 5'b00001, reset value of counter. Must be nonzero.

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high reset
- key_start  in  1  start key level, synchronous to frame_clk
- all_eaten  in  1  level; high when no pellets remain
- PacX, PacY  in  10 each  Pac-Man top-left position
- GhostX0..GhostX3  in  10 each  ghost top-left X (0 Blinky, 1 Pinky, 2 Inky, 3 Clyde)
- GhostY0..GhostY3  in  10 each  ghost top-left Y, same index order
- start_game  out  1  high only in PLAY
- game_over  out  1  high in OVER and WIN
- win  out  1  high in WIN only
- lives  out  2  remaining lives
- hit_ghost  out  2  index of the ghost that caused the last death
- respawn  out  1  one-cycle pulse; motion blocks reload their centre positions
- counter  out  5  free-running LFSR value

Behaviour:
- Clock and reset: one clock, frame_clk. Reset is asynchronous and active-high, named Reset. All registers clear immediately on Reset, including mid-game.
- Reset values:
  - state = IDLE; start_game = 0; game_over = 0; win = 0
  - lives = LIVES_INIT; hit_ghost = 0; respawn = 0
  - counter = LFSR_SEED; key_start_q = 0; death timer = 0
- Start edge: key_start is registered into key_start_q. start_edge = key_start & ~key_start_q.
- Collision, per ghost i, combinational:
  - dx = |PacX - GhostXi| and dy = |PacY - GhostYi|, both computed 11-bit unsigned.
  - hit_i = (dx < SPRITE_SIZE) & (dy < SPRITE_SIZE).
  - any_hit = OR of hit_i. The lowest colliding index wins for hit_ghost.
- LFSR:
  - Taps x^5 + x^3 + 1, Fibonacci form: new bit = counter[4] ^ counter[2], shifted in at bit 0.
  - Advances every frame_clk in every state.
  - Period 31; never reaches 0.
- States: IDLE, PLAY, DYING, OVER, WIN. Outputs are registered and decoded from the state register, so each output changes on the same edge as the state change.
- IDLE: start_edge -> PLAY; lives <= LIVES_INIT; respawn pulses on the entry cycle.
- PLAY:
  - all_eaten -> WIN. all_eaten has priority over any_hit in the same cycle.
  - Otherwise any_hit -> DYING; lives <= lives - 1, saturating at 0; hit_ghost captured; timer <= 0.
  - Otherwise stay in PLAY.
- DYING:
  - start_game = 0, so ghosts and Pac-Man freeze.
  - Timer increments each frame.
  - When timer == DEATH_FRAMES - 1: if lives == 0 -> OVER, else -> PLAY with a respawn pulse. The respawn pulse is high for exactly the first PLAY cycle.
  - DYING lasts exactly DEATH_FRAMES cycles.
  - Collisions and all_eaten are ignored while in DYING.
- OVER / WIN: outputs held. start_edge -> PLAY with lives reload and a respawn pulse. This skips IDLE.
- Respawn suppression: collision is not evaluated in the first PLAY cycle after respawn. Positions are still stale on that cycle.
- key_start held high produces only one start_edge; the player must release and press again.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package game_pkg:
  - game_state_t enum: IDLE, PLAY, DYING, OVER, WIN
  - SPRITE_SIZE default constant
  - ghost index constants GHOST_BLINKY..GHOST_CLYDE
- Sub-module sprite_overlap: purely combinational. Takes two 10-bit X/Y pairs plus the SIZE parameter and returns hit. Instantiated four times.
- The FSM, lives counter, death timer and LFSR live in game_state_ctrl.

Test Plan:
- Reset, then 31 frames with idle inputs -> state IDLE; start_game = 0, lives = 3, counter = 5'b00001. Counter sequence returns to 5'b00001 after exactly 31 frames and never reads 0.
- key_start held high 10 frames -> exactly one transition to PLAY and one respawn pulse; start_game = 1 from the following edge.
- PLAY with PacX = 100, PacY = 100:
  - GhostX2 = 115, GhostY2 = 100 (dx = 15) -> DYING next edge; lives = 2; hit_ghost = 2; start_game = 0 for exactly 60 frames; then PLAY with respawn.
  - GhostX2 = 116 -> no hit.
- Ghost 0 and ghost 3 overlapping in the same cycle -> hit_ghost = 0. Collision and all_eaten in the same cycle -> WIN: win = 1, game_over = 1, lives unchanged.
- Three successive deaths -> lives 3 -> 2 -> 1 -> 0. After the third DYING, OVER with game_over = 1. A new start_edge -> PLAY, lives = 3, respawn pulse.
- Reset asserted mid-DYING at timer = 30 -> outputs take their reset values immediately, without waiting for a clock edge. After release, a fresh start gives a full 60-frame death on the next collision.
